// File: rtl/sudoku_pkg.sv
// sudoku_pkg: shared state encoding, sizes and cursor arithmetic for the Sudoku input path
package sudoku_pkg;
    localparam int CELL_W  = 4;
    localparam int VAL_W   = 2;
    localparam int DIFF_W  = 2;
    localparam int N_CELLS = 16;
    localparam int NAV_W   = 4;
    typedef enum logic [2:0] {IDLE, LOAD, EDIT, COMMIT, CHECK, WAIT, WON} state_t;
    // step bits: 0 up, 1 down, 2 left, 3 right; wrap stays inside the row/column
    function automatic logic [CELL_W-1:0] move_cell(input logic [CELL_W-1:0] c, input logic [NAV_W-1:0] s);
        logic [1:0] r;
        logic [1:0] k;
        r = c[3:2];
        k = c[1:0];
        r = s[0] ? r - 2'd1 : s[1] ? r + 2'd1 : r;
        k = s[2] ? k - 2'd1 : s[3] ? k + 2'd1 : k;
        return {r, k};
    endfunction
endpackage

// File: rtl/sudoku_input_ctrl_if.sv
// sudoku_input_ctrl_if: player buttons, dp feedback and dp command bundle
interface sudoku_input_ctrl_if;
    import sudoku_pkg::*;
    logic                  btn_up;
    logic                  btn_down;
    logic                  btn_left;
    logic                  btn_right;
    logic                  btn_inc;
    logic                  btn_enter;
    logic                  btn_new;
    logic [DIFF_W-1:0]     diff_sel;
    logic [N_CELLS-1:0]    fill_flag;
    logic                  solved;
    logic [CELL_W-1:0]     reg_choose;
    logic [VAL_W-1:0]      value_inp;
    logic [DIFF_W-1:0]     difficulty;
    logic                  set_board;
    logic                  register_inp_flag;
    logic                  dp_check;
    logic                  try_again_flag;
    logic                  won;
    logic                  reject;
    modport master (
        input  btn_up, btn_down, btn_left, btn_right, btn_inc, btn_enter, btn_new,
        input  diff_sel, fill_flag, solved,
        output reg_choose, value_inp, difficulty, set_board, register_inp_flag,
        output dp_check, try_again_flag, won, reject
    );
    modport slave (
        output btn_up, btn_down, btn_left, btn_right, btn_inc, btn_enter, btn_new,
        output diff_sel, fill_flag, solved,
        input  reg_choose, value_inp, difficulty, set_board, register_inp_flag,
        input  dp_check, try_again_flag, won, reject
    );
endinterface

// File: rtl/btn_edge_repeat.sv
// btn_edge_repeat: nav press edges plus hold auto-repeat, reduced to one-hot with bit 0 highest priority
module btn_edge_repeat #(
    parameter int REPEAT_CYCLES = 8,
    parameter int CNT_W = 4
) (
    input  logic       clka,
    input  logic       restart,
    input  logic [3:0] btn,
    output logic [3:0] step
);
    logic [3:0]       prv;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             held;
    logic             fire;
    logic [3:0]       ev;
    always_comb begin
        held    = REPEAT_CYCLES > 0 && btn == prv && btn != 4'd0 && (btn & (btn - 4'd1)) == 4'd0;
        cnt_inc = cnt + 1'b1;
        fire    = held && cnt_inc == CNT_W'(REPEAT_CYCLES);
        ev      = (btn & ~prv) | (fire ? btn : 4'd0);
        step    = ev & (~ev + 4'd1);
    end
    always_ff @(posedge clka or negedge restart) begin
        if (!restart) begin
            prv <= '0;
            cnt <= '0;
        end else begin
            prv <= btn;
            cnt <= held && !fire ? cnt_inc : '0;
        end
    end
endmodule

// File: rtl/sudoku_input_ctrl.sv
// sudoku_input_ctrl: turns player buttons into registered dp command pulses and tracks cursor/value/won
module sudoku_input_ctrl
    import sudoku_pkg::*;
#(
    parameter int REPEAT_CYCLES = 8,
    parameter int CNT_W = 4
) (
    input logic                 clka,
    input logic                 restart,
    sudoku_input_ctrl_if.master bus
);
    state_t              st, st_n;
    logic [CELL_W-1:0]   cur, cur_n;
    logic [VAL_W-1:0]    val, val_n;
    logic [DIFF_W-1:0]   diff, diff_n;
    logic [2:0]          prv;
    logic                inc_p, ent_p, new_p;
    logic [NAV_W-1:0]    step;
    logic                set_q, reg_q, chk_q, try_q, won_q, rej_q;
    logic                try_n, rej_n;
    btn_edge_repeat #(.REPEAT_CYCLES(REPEAT_CYCLES), .CNT_W(CNT_W)) u_nav (
        .clka    (clka),
        .restart (restart),
        .btn     ({bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up}),
        .step    (step)
    );
    assign inc_p = bus.btn_inc & ~prv[0];
    assign ent_p = bus.btn_enter & ~prv[1];
    assign new_p = bus.btn_new & ~prv[2];
    always_comb begin
        st_n  = st;
        cur_n = cur;
        val_n = val;
        diff_n = diff;
        try_n = 1'b0;
        rej_n = 1'b0;
        case (st)
            IDLE:   st_n = new_p ? LOAD : IDLE;
            LOAD:   st_n = EDIT;
            EDIT: begin
                if (new_p) st_n = LOAD;
                else if (ent_p) begin
                    rej_n = bus.fill_flag[cur];
                    st_n  = bus.fill_flag[cur] ? EDIT : COMMIT;
                end
                else if (inc_p) val_n = val + 1'b1;
                else cur_n = move_cell(cur, step);
            end
            COMMIT: st_n = CHECK;
            CHECK:  st_n = WAIT;
            WAIT:   st_n = bus.solved ? WON : EDIT;
            WON: begin
                if (new_p) st_n = LOAD;
                else if (ent_p) begin
                    st_n  = EDIT;
                    try_n = 1'b1;
                end
            end
            default: st_n = IDLE;
        endcase
        if (st_n == LOAD) begin
            cur_n  = '0;
            val_n  = '0;
            diff_n = bus.diff_sel;
        end
    end
    always_ff @(posedge clka or negedge restart) begin
        if (!restart) begin
            st    <= IDLE;
            cur   <= '0;
            val   <= '0;
            diff  <= '0;
            prv   <= '0;
            set_q <= 1'b0;
            reg_q <= 1'b0;
            chk_q <= 1'b0;
            try_q <= 1'b0;
            won_q <= 1'b0;
            rej_q <= 1'b0;
        end else begin
            st    <= st_n;
            cur   <= cur_n;
            val   <= val_n;
            diff  <= diff_n;
            prv   <= {bus.btn_new, bus.btn_enter, bus.btn_inc};
            set_q <= st_n == LOAD;
            reg_q <= st_n == COMMIT;
            chk_q <= st_n == CHECK;
            try_q <= try_n;
            won_q <= st_n == WON;
            rej_q <= rej_n;
        end
    end
    assign bus.reg_choose        = cur;
    assign bus.value_inp         = val;
    assign bus.difficulty        = diff;
    assign bus.set_board         = set_q;
    assign bus.register_inp_flag = reg_q;
    assign bus.dp_check          = chk_q;
    assign bus.try_again_flag    = try_q;
    assign bus.won               = won_q;
    assign bus.reject            = rej_q;
endmodule

// File: tb/tb_sudoku_input_ctrl.sv
// tb_sudoku_input_ctrl: directed stimulus with hand-computed expectations for sudoku_input_ctrl
module tb_sudoku_input_ctrl;
    localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3, INC = 4, ENTER = 5, NEW = 6;
    logic clka = 1'b0;
    logic restart = 1'b0;
    int   errors = 0;
    int   checks = 0;
    sudoku_input_ctrl_if bus();
    sudoku_input_ctrl #(.REPEAT_CYCLES(8), .CNT_W(4)) dut (
        .clka    (clka),
        .restart (restart),
        .bus     (bus)
    );
    always #5 clka = ~clka;
    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clka);
        #1;
    endtask
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic set_btn(input int which, input logic v);
        case (which)
            UP:      bus.btn_up = v;
            DOWN:    bus.btn_down = v;
            LEFT:    bus.btn_left = v;
            RIGHT:   bus.btn_right = v;
            INC:     bus.btn_inc = v;
            ENTER:   bus.btn_enter = v;
            default: bus.btn_new = v;
        endcase
    endtask
    task automatic press(input int which);
        set_btn(which, 1'b1);
        cyc();
        set_btn(which, 1'b0);
        cyc();
    endtask
    initial begin
        bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
        bus.btn_inc = 0; bus.btn_enter = 0; bus.btn_new = 0;
        bus.diff_sel = 0; bus.fill_flag = 0; bus.solved = 0;
        cyc(2);
        chk("rst_rc", 16'(bus.reg_choose), 16'd0);
        chk("rst_val", 16'(bus.value_inp), 16'd0);
        chk("rst_diff", 16'(bus.difficulty), 16'd0);
        chk("rst_pulses", 16'({bus.set_board, bus.register_inp_flag, bus.dp_check, bus.try_again_flag, bus.won, bus.reject}), 16'd0);
        restart = 1'b1;
        cyc();
        bus.diff_sel = 2'd2;
        set_btn(NEW, 1'b1);
        cyc();
        chk("load_set", 16'(bus.set_board), 16'd1);
        chk("load_diff", 16'(bus.difficulty), 16'd2);
        chk("load_rc", 16'(bus.reg_choose), 16'd0);
        set_btn(NEW, 1'b0);
        cyc();
        chk("load_set_drop", 16'(bus.set_board), 16'd0);
        press(LEFT);
        chk("left_wrap", 16'(bus.reg_choose), 16'd3);
        press(UP);
        chk("up_wrap", 16'(bus.reg_choose), 16'd15);
        press(RIGHT);
        chk("right_wrap", 16'(bus.reg_choose), 16'd12);
        repeat (5) press(INC);
        chk("inc_x5", 16'(bus.value_inp), 16'd1);
        bus.diff_sel = 2'd3;
        bus.fill_flag = 16'h0001;
        press(DOWN);
        chk("down_wrap", 16'(bus.reg_choose), 16'd0);
        chk("diff_latched", 16'(bus.difficulty), 16'd2);
        set_btn(ENTER, 1'b1);
        cyc();
        chk("reject_hi", 16'(bus.reject), 16'd1);
        chk("reject_no_wr", 16'(bus.register_inp_flag), 16'd0);
        set_btn(ENTER, 1'b0);
        cyc();
        chk("reject_lo", 16'(bus.reject), 16'd0);
        chk("reject_no_wr2", 16'(bus.register_inp_flag), 16'd0);
        press(DOWN);
        press(RIGHT);
        chk("cell5", 16'(bus.reg_choose), 16'd5);
        set_btn(ENTER, 1'b1);
        cyc();
        chk("commit_wr", 16'(bus.register_inp_flag), 16'd1);
        chk("commit_chk", 16'(bus.dp_check), 16'd0);
        chk("commit_rc", 16'(bus.reg_choose), 16'd5);
        set_btn(ENTER, 1'b0);
        cyc();
        chk("check_wr", 16'(bus.register_inp_flag), 16'd0);
        chk("check_chk", 16'(bus.dp_check), 16'd1);
        chk("check_rc", 16'(bus.reg_choose), 16'd5);
        bus.solved = 1'b1;
        cyc();
        chk("wait_chk", 16'(bus.dp_check), 16'd0);
        chk("wait_won", 16'(bus.won), 16'd0);
        chk("wait_rc", 16'(bus.reg_choose), 16'd5);
        cyc();
        bus.solved = 1'b0;
        chk("won_hi", 16'(bus.won), 16'd1);
        cyc(3);
        chk("won_held", 16'(bus.won), 16'd1);
        chk("won_val", 16'(bus.value_inp), 16'd1);
        press(RIGHT);
        chk("won_nav_ignored", 16'(bus.reg_choose), 16'd5);
        chk("won_still", 16'(bus.won), 16'd1);
        set_btn(ENTER, 1'b1);
        cyc();
        chk("try_hi", 16'(bus.try_again_flag), 16'd1);
        chk("try_won_lo", 16'(bus.won), 16'd0);
        set_btn(ENTER, 1'b0);
        cyc();
        chk("try_lo", 16'(bus.try_again_flag), 16'd0);
        set_btn(ENTER, 1'b1);
        cyc();
        chk("unsolved_wr", 16'(bus.register_inp_flag), 16'd1);
        set_btn(ENTER, 1'b0);
        cyc(3);
        chk("unsolved_won", 16'(bus.won), 16'd0);
        cyc();
        set_btn(ENTER, 1'b1);
        set_btn(RIGHT, 1'b1);
        cyc();
        chk("prio_wr", 16'(bus.register_inp_flag), 16'd1);
        chk("prio_rc", 16'(bus.reg_choose), 16'd5);
        set_btn(ENTER, 1'b0);
        set_btn(RIGHT, 1'b0);
        cyc(4);
        chk("prio_rc_after", 16'(bus.reg_choose), 16'd5);
        chk("prio_won", 16'(bus.won), 16'd0);
        set_btn(DOWN, 1'b1);
        cyc();
        chk("hold_first", 16'(bus.reg_choose), 16'd9);
        cyc(19);
        set_btn(DOWN, 1'b0);
        cyc();
        chk("hold_3steps", 16'(bus.reg_choose), 16'd1);
        set_btn(ENTER, 1'b1);
        cyc();
        chk("pre_rst_wr", 16'(bus.register_inp_flag), 16'd1);
        #2 restart = 1'b0;
        #1;
        chk("async_wr", 16'(bus.register_inp_flag), 16'd0);
        chk("async_rc", 16'(bus.reg_choose), 16'd0);
        chk("async_val", 16'(bus.value_inp), 16'd0);
        chk("async_diff", 16'(bus.difficulty), 16'd0);
        set_btn(ENTER, 1'b0);
        cyc();
        restart = 1'b1;
        cyc(2);
        set_btn(ENTER, 1'b1);
        cyc();
        chk("idle_enter_wr", 16'(bus.register_inp_flag), 16'd0);
        chk("idle_enter_rej", 16'(bus.reject), 16'd0);
        set_btn(ENTER, 1'b0);
        cyc(2);
        chk("idle_enter_chk", 16'(bus.dp_check), 16'd0);
        bus.diff_sel = 2'd1;
        set_btn(NEW, 1'b1);
        cyc();
        chk("reload_set", 16'(bus.set_board), 16'd1);
        chk("reload_diff", 16'(bus.difficulty), 16'd1);
        set_btn(NEW, 1'b0);
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/sudoku_input_ctrl.md
Name: sudoku_input_ctrl

Overview:
- Upstream stage of the 4x4 Sudoku datapath (dp).
- Converts raw player buttons into dp command pulses: set_board, register_inp_flag, dp_check and try_again_flag, plus reg_choose, value_inp and difficulty.
- Tracks cursor and candidate value, refuses writes to given (pre-filled) cells, and holds the won indication.
- Consumes dp's fill_flag and solved.

Parameters:
- REPEAT_CYCLES, 8, cycles a navigation button must be held before it auto-repeats one step (and again every REPEAT_CYCLES cycles while held); 0 disables auto-repeat.
- CNT_W, 4, width of the auto-repeat counter; must satisfy REPEAT_CYCLES < 2^CNT_W.

Ports:
- clka  in  1  single system clock; all state updates on the rising edge.
- restart  in  1  reset; asynchronous, active-low.
- btn_up / btn_down / btn_left / btn_right  in  1 each  navigation levels, already synchronised.
- btn_inc  in  1  cycles the candidate value.
- btn_enter  in  1  commits the candidate; in WON, requests a replay.
- btn_new  in  1  starts a new game.
- diff_sel  in  2  difficulty requested for the next game.
- fill_flag  in  16  from dp; bit i = 1 means cell i is a given and must not be written.
- solved  in  1  from dp; valid in the cycle after the dp_check pulse.
- reg_choose  out  4  cursor cell index = row*4+col.
- value_inp  out  2  candidate value.
- difficulty  out  2  difficulty latched for the current game.
- set_board  out  1  one-cycle pulse that loads a new board.
- register_inp_flag  out  1  one-cycle write strobe.
- dp_check  out  1  one-cycle check strobe.
- try_again_flag  out  1  one-cycle replay pulse.
- won  out  1  level; high while in WON.
- reject  out  1  one-cycle pulse when enter is refused on a given cell.

Behaviour:
- Reset (restart low, asynchronous): state = IDLE; all outputs 0; cursor 0; value 0; difficulty 0; repeat counter 0; previous-button registers 0.
- Press detection: a press is a rising edge of a button, compared against the registered value from the previous cycle. Navigation buttons also auto-repeat when REPEAT_CYCLES > 0:
  - the counter increments while exactly the same single nav button stays high;
  - when it reaches REPEAT_CYCLES it produces one extra step and clears to 0;
  - it clears on release or on a change of button.
- Priority for same-cycle presses: btn_new > btn_enter > btn_inc > up > down > left > right. Only the highest-priority press acts in a given cycle; the rest are discarded.
- Cursor arithmetic (row = reg_choose[3:2], col = reg_choose[1:0]):
  - up = row-1 mod 4; down = row+1 mod 4;
  - left = col-1 mod 4; right = col+1 mod 4;
  - wrap stays within the same row/column (e.g. right from cell 3 goes to cell 0, up from cell 1 goes to cell 13).
- btn_inc: value_inp = value_inp+1 mod 4 (3 wraps to 0).
- FSM:
  - IDLE: btn_new -> LOAD. All other presses are ignored.
  - LOAD: set_board = 1 for exactly this cycle; difficulty <= diff_sel, captured on entry; cursor <= 0; value <= 0. Next state EDIT.
  - EDIT: navigation and inc act as above.
    - btn_enter with fill_flag[reg_choose] = 1: reject pulses for 1 cycle; stay in EDIT.
    - btn_enter with fill_flag[reg_choose] = 0: -> COMMIT.
    - btn_new: -> LOAD.
  - COMMIT: register_inp_flag = 1 for one cycle. reg_choose and value_inp are frozen from entry to COMMIT until the state returns to EDIT. Next state CHECK.
  - CHECK: dp_check = 1 for one cycle. Next state WAIT.
  - WAIT: sample solved. solved = 1 -> WON; otherwise -> EDIT.
  - WON: won = 1.
    - btn_enter: try_again_flag = 1 for one cycle -> EDIT; won drops in the same cycle as the pulse.
    - btn_new: -> LOAD.
    - Navigation and inc are ignored.
- Buttons pressed during COMMIT, CHECK or WAIT are dropped, not queued. Their edge history is still updated, so a held button does not re-fire on exit.
- btn_new is ignored during COMMIT, CHECK and WAIT, so a write/check sequence always completes.
- Pulse outputs are registered and never high for two consecutive cycles.
- Reset asserted mid-sequence (e.g. in COMMIT) clears the pulse immediately (asynchronous) and returns to IDLE.

Decomposition:
- Shared package sudoku_pkg: state encoding (IDLE, LOAD, EDIT, COMMIT, CHECK, WAIT, WON; 3 bits), CELL_W = 4, VAL_W = 2, DIFF_W = 2, N_CELLS = 16.
- Sub-module btn_edge_repeat (parameter REPEAT_CYCLES): one instance handles the four navigation buttons and outputs a one-hot step vector. Edge detection for inc, enter and new stays inline.

Test Plan:
- Reset, release, btn_new with diff_sel = 2 -> set_board high exactly one cycle, 1 cycle after the press edge; difficulty = 2; reg_choose = 0; state EDIT.
- In EDIT from cell 0: left -> reg_choose = 3; up -> 15; right -> 12; btn_inc x5 -> value_inp = 1.
- fill_flag = 16'h0001, cursor 0, btn_enter -> reject one cycle; no register_inp_flag. Move to cell 5, enter -> register_inp_flag at T, dp_check at T+1, reg_choose = 5 stable throughout.
- solved = 1 in the WAIT cycle -> won = 1 and held. btn_enter -> try_again_flag one cycle and won = 0. With solved = 0 instead -> back to EDIT, won stays 0.
- btn_enter and btn_right rising in the same cycle on a free cell -> only the commit sequence runs; cursor unchanged. Hold btn_down 20 cycles with REPEAT_CYCLES = 8 -> exactly 3 down steps.
- Assert restart low during COMMIT -> register_inp_flag falls without waiting for a clock edge; all outputs 0; after release btn_enter is ignored until btn_new.
